data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Data-memory responder on the CPU MEM-stage interface (target side of mem_addr/write_data/
//   memory_read/memory_write; returns writeback_data). Single-port doubleword storage; stores
//   are posted into an in-order write buffer and retired on idle cycles. Reads are serviced
//   same-cycle with forwarding from pending stores. mem_stall holds the CPU when the buffer is full.
// PARAMETERS
//   DEPTH_WORDS  256  number of 64-bit words in storage (power of 2)
//   IDX_W        8    log2(DEPTH_WORDS)
//   WB_DEPTH     4    posted-write buffer entries (power of 2, >=2)
// PORTS
//   clock           in   1   sole clock, rising edge
//   reset           in   1   asynchronous, active-low reset
//   mem_addr        in   64  byte address from EX/MEM ALU result
//   write_data      in   64  store data (Rt contents)
//   memory_read     in   1   load request this cycle
//   memory_write    in   1   store request this cycle
//   writeback_data  out  64  load data, combinational, captured by MEM/WB at next edge
//   mem_stall       out  1   store not accepted this cycle; CPU must hold request
//   wb_count        out  3   pending buffer entries (debug), 0..WB_DEPTH
// BEHAVIOUR
//   Addressing: idx = mem_addr[IDX_W+2:3]; bits [2:0] ignored (doubleword only); bits above
//     IDX_W+2 ignored (address wraps modulo DEPTH_WORDS*8).
//   Reset (reset==0, async): buffer head/tail/count = 0, all entries invalid; mem_stall=0,
//     wb_count=0. Storage array is NOT cleared. Reset mid-operation discards pending stores.
//   Write buffer: circular FIFO of {idx, data}; head/tail pointers wrap modulo WB_DEPTH;
//     separate count distinguishes full from empty.
//   Per-cycle request class (priority order):
//     READ  (memory_read=1): writeback_data = youngest buffer entry with matching idx, else
//       storage[idx]. Storage port consumed by read -> no drain.
//     WRITE (memory_write=1, memory_read=0):
//       - count<WB_DEPTH: push {idx,write_data} at tail at edge; mem_stall=0. No drain.
//       - count==WB_DEPTH: mem_stall=1 (combinational), no push; head drains to storage at
//         edge (port otherwise idle). Store accepted next cycle -> full-stall lasts 1 cycle.
//     IDLE (neither): if count>0, storage[head.idx] <= head.data at edge; pop head.
//     BOTH asserted: illegal from CPU; treated as READ (no push, no drain), writeback_data valid.
//   writeback_data = 0 whenever memory_read=0.
//   Ordering: drains in program order; multiple entries to same idx all retire in order,
//     so storage ends with youngest value. Forwarding compares all valid entries; youngest wins.
//   Latency: load 0 cycles (combinational); store visible to subsequent loads from the cycle
//     after acceptance via forwarding; visible in storage after drain.
//   mem_stall depends only on memory_write, memory_read and count (no path from mem_addr).
//   wb_count = count register.
// TESTING
//   1. Reset low mid-run with 3 pending stores -> wb_count=0 immediately; stale stores never
//      reach storage; subsequent load of those idx returns prior storage value.
//   2. Store 0xDEAD_BEEF to addr 0x10, next cycle load 0x10 -> writeback_data=0xDEADBEEF via
//      forwarding, wb_count=1; after 1 idle cycle wb_count=0 and load still returns 0xDEADBEEF.
//   3. Stores 0x1,0x2,0x3 to addr 0x08 back-to-back, then load 0x08 -> 0x3 (youngest);
//      after 3 idle cycles storage[1]=0x3.
//   4. 5 back-to-back stores (WB_DEPTH=4) -> 5th cycle mem_stall=1, wb_count stays 4 with head
//      drained; next cycle store accepted, mem_stall=0, wb_count=4.
//   5. Load addr 0x807 with DEPTH_WORDS=256 -> reads idx 0 (wrap, low bits ignored).
//   6. memory_read and memory_write both high with count=2 -> no push/drain, wb_count=2, data valid.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU MEM stage: doubleword storage behind a posted,
// in-order write buffer, with same-cycle loads forwarded from pending stores.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8,
    parameter int WB_DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] mem_addr,
    input  logic [63:0] write_data,
    input  logic        memory_read,
    input  logic        memory_write,
    output logic [63:0] writeback_data,
    output logic        mem_stall,
    output logic [2:0]  wb_count
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    typedef logic [IDX_W-1:0] idx_t;

    logic [63:0]       storage [DEPTH_WORDS];

    idx_t              wb_idx_reg  [WB_DEPTH];
    logic [63:0]       wb_data_reg [WB_DEPTH];
    logic [WB_DEPTH-1:0] wb_valid_reg;
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [PTR_W:0]    count_reg, count_next;

    idx_t              req_idx;
    logic              buf_full, buf_empty;
    logic              is_write, push, drain;
    logic [WB_DEPTH-1:0] fwd_hit;
    logic [63:0]       fwd_data [WB_DEPTH];
    logic [63:0]       rd_word;
    logic              unused_addr_bits;

    // Doubleword addressing: byte offset and bits above the array size are dropped.
    assign req_idx          = mem_addr[IDX_W+2:3];
    assign unused_addr_bits = ^{mem_addr[63:IDX_W+3], mem_addr[2:0]};

    assign buf_full  = (count_reg == (PTR_W+1)'(WB_DEPTH));
    assign buf_empty = (count_reg == '0);

    // A read owns the storage port; a stalled store leaves it free for a drain.
    assign is_write  = memory_write & ~memory_read;
    assign push      = is_write & ~buf_full;
    assign drain     = ~memory_read & ~buf_empty & (~memory_write | buf_full);
    assign mem_stall = is_write & buf_full;
    assign wb_count  = 3'(count_reg);

    always_comb begin
        count_next = count_reg;
        if (push && !drain) begin
            count_next = count_reg + (PTR_W+1)'(1);
        end else if (drain && !push) begin
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    // Slot gi of the forwarding view is the gi-th oldest entry (gi=0 is the head).
    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_fwd
            logic [PTR_W-1:0] pos;
            assign pos          = head_reg + PTR_W'(gi);
            assign fwd_hit[gi]  = wb_valid_reg[pos] && (wb_idx_reg[pos] == req_idx);
            assign fwd_data[gi] = wb_data_reg[pos];
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        rd_word = storage[req_idx];
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (fwd_hit[k]) begin
                rd_word = fwd_data[k];
            end
        end
        writeback_data = memory_read ? rd_word : 64'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            wb_valid_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                tail_reg               <= tail_reg + PTR_W'(1);
                wb_valid_reg[tail_reg] <= 1'b1;
            end
            if (drain) begin
                head_reg               <= head_reg + PTR_W'(1);
                wb_valid_reg[head_reg] <= 1'b0;
            end
        end
    end

    // Entry payloads need no reset; the valid bits gate every use of them.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_idx_reg[tail_reg]  <= req_idx;
            wb_data_reg[tail_reg] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (drain) begin
            storage[wb_idx_reg[head_reg]] <= wb_data_reg[head_reg];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scenario bench for data_mem_responder: load expectations are queued when a load is
// issued and popped when the combinational load result is sampled.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] write_data = '0;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic [63:0] writeback_data;
    logic        mem_stall;
    logic [2:0]  wb_count;

    int checks = 0;
    int passed = 0;
    logic [63:0] exp_q [$];

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .IDX_W(8),
        .WB_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_addr(mem_addr),
        .write_data(write_data),
        .memory_read(memory_read),
        .memory_write(memory_write),
        .writeback_data(writeback_data),
        .mem_stall(mem_stall),
        .wb_count(wb_count)
    );

    always #5 clock = ~clock;

    // One request per cycle: inputs change just after the edge, outputs sampled at negedge.
    task automatic drive(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
        @(posedge clock);
        #1;
        memory_read  = rd;
        memory_write = wr;
        mem_addr     = a;
        write_data   = d;
        @(negedge clock);
        $display("t=%0t rd=%b wr=%b addr=%h wdata=%h -> rdata=%h stall=%b cnt=%0d",
                 $time, rd, wr, a, d, writeback_data, mem_stall, wb_count);
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        drive(1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] e);
        exp_q.push_back(e);
        drive(1'b1, 1'b0, a, 64'd0);
    endtask

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [63:0] e;
        #2;
        checks++; if (wb_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", wb_count); else passed++;
        checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", mem_stall); else passed++;
        checks++; if (writeback_data !== 64'd0) $display("FAIL reset_rdata got=%h want=0", writeback_data); else passed++;
        @(negedge clock);
        reset = 1'b1;
        // Idle read-off check: no read means zero data regardless of address.
        drive(1'b0, 1'b0, 64'h807, 64'd0);
        checks++; if (writeback_data !== 64'd0) $display("FAIL idle_rdata got=%h want=0", writeback_data); else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] e;
        store(64'h20, 64'h111);
        store(64'h28, 64'h222);
        store(64'h30, 64'h333);
        idle(3);
        store(64'h20, 64'hAAA);
        checks++; if (writeback_data !== 64'd0) $display("FAIL store_rdata got=%h want=0", writeback_data); else passed++;
        store(64'h28, 64'hBBB);
        store(64'h30, 64'hCCC);
        @(posedge clock);
        #1;
        memory_write = 1'b0;
        checks++; if (wb_count !== 3'd3) $display("FAIL mid_pre_count got=%0d want=3", wb_count); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (wb_count !== 3'd0) $display("FAIL mid_async_count got=%0d want=0", wb_count); else passed++;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        load(64'h20, 64'h111);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL mid_load4 got=%h want=%h", writeback_data, e); else passed++;
        load(64'h28, 64'h222);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL mid_load5 got=%h want=%h", writeback_data, e); else passed++;
        load(64'h30, 64'h333);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL mid_load6 got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd0) $display("FAIL mid_post_count got=%0d want=0", wb_count); else passed++;
    endtask

    task automatic test_forwarding();
        logic [63:0] e;
        store(64'h10, 64'hDEAD_BEEF);
        load(64'h10, 64'hDEAD_BEEF);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL fwd_load got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd1) $display("FAIL fwd_count got=%0d want=1", wb_count); else passed++;
        idle(1);
        load(64'h10, 64'hDEAD_BEEF);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL drained_load got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd0) $display("FAIL drained_count got=%0d want=0", wb_count); else passed++;
    endtask

    task automatic test_youngest_wins();
        logic [63:0] e;
        store(64'h08, 64'h1);
        store(64'h08, 64'h2);
        store(64'h08, 64'h3);
        load(64'h08, 64'h3);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL young_fwd got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd3) $display("FAIL young_count got=%0d want=3", wb_count); else passed++;
        idle(3);
        load(64'h08, 64'h3);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL young_storage got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd0) $display("FAIL young_drained got=%0d want=0", wb_count); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        for (int i = 0; i < 4; i++) begin
            store(64'h100 + 64'(i * 8), 64'h50 + 64'(i));
            checks++; if (mem_stall !== 1'b0) $display("FAIL b2b_stall%0d got=%b want=0", i, mem_stall); else passed++;
        end
        store(64'h120, 64'h54);
        checks++; if (mem_stall !== 1'b1) $display("FAIL full_stall got=%b want=1", mem_stall); else passed++;
        checks++; if (wb_count !== 3'd4) $display("FAIL full_count got=%0d want=4", wb_count); else passed++;
        store(64'h120, 64'h54);
        checks++; if (mem_stall !== 1'b0) $display("FAIL retry_stall got=%b want=0", mem_stall); else passed++;
        checks++; if (wb_count !== 3'd3) $display("FAIL retry_count got=%0d want=3", wb_count); else passed++;
        load(64'h100, 64'h50);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL full_drained_head got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd4) $display("FAIL accepted_count got=%0d want=4", wb_count); else passed++;
        load(64'h120, 64'h54);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL full_fwd_tail got=%h want=%h", writeback_data, e); else passed++;
        idle(4);
        for (int i = 0; i < 5; i++) begin
            load(64'h100 + 64'(i * 8), 64'h50 + 64'(i));
            e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL b2b_load%0d got=%h want=%h", i, writeback_data, e); else passed++;
        end
        checks++; if (wb_count !== 3'd0) $display("FAIL b2b_final_count got=%0d want=0", wb_count); else passed++;
    endtask

    task automatic test_addr_wrap();
        logic [63:0] e;
        store(64'h0, 64'h5A5A_0000_1234);
        store(64'h7F8, 64'hF00D);
        idle(2);
        load(64'h807, 64'h5A5A_0000_1234);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL wrap_807 got=%h want=%h", writeback_data, e); else passed++;
        load(64'hFFFF_FFFF_FFFF_F800, 64'h5A5A_0000_1234);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL wrap_high got=%h want=%h", writeback_data, e); else passed++;
        load(64'hFFF, 64'hF00D);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL wrap_top got=%h want=%h", writeback_data, e); else passed++;
    endtask

    task automatic test_read_write_both();
        logic [63:0] e;
        store(64'h50, 64'h1010);
        idle(1);
        store(64'h50, 64'h2020);
        store(64'h58, 64'h3030);
        exp_q.push_back(64'h2020);
        drive(1'b1, 1'b1, 64'h50, 64'hBAD);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL both_rdata got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd2) $display("FAIL both_count got=%0d want=2", wb_count); else passed++;
        checks++; if (mem_stall !== 1'b0) $display("FAIL both_stall got=%b want=0", mem_stall); else passed++;
        exp_q.push_back(64'h3030);
        drive(1'b1, 1'b1, 64'h58, 64'hBAD);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL both_rdata2 got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd2) $display("FAIL both_count2 got=%0d want=2", wb_count); else passed++;
        idle(2);
        load(64'h50, 64'h2020);
        e = pop_exp(); checks++; if (writeback_data !== e) $display("FAIL both_after_drain got=%h want=%h", writeback_data, e); else passed++;
        checks++; if (wb_count !== 3'd0) $display("FAIL both_final_count got=%0d want=0", wb_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_forwarding();
        test_youngest_wins();
        test_back_to_back();
        test_addr_wrap();
        test_read_write_both();
        checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
